// File: rtl/pll_reset_sequencer_pkg.sv
// rtl/pll_reset_sequencer_pkg.sv - shared state encoding and cycle defaults for the PLL reset sequencer
//
// Holds:
//   seq_state_t       2-bit sequencer state (RESET_PLL=0, WAIT_LOCK=1, STABILIZE=2, RUN=3)
//   DEF_*             default cycle counts for a 27 MHz reference oscillator
//   cnt_width()       width of the shared phase counter for a given set of cycle counts

package pll_reset_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_RESET_PLL = 2'd0,
    ST_WAIT_LOCK = 2'd1,
    ST_STABILIZE = 2'd2,
    ST_RUN       = 2'd3
  } seq_state_t;

  localparam int DEF_PLL_RST_CYCLES = 16;     // PLL reset pulse length
  localparam int DEF_LOCK_TIMEOUT   = 27000;  // 1 ms at 27 MHz
  localparam int DEF_STABLE_CYCLES  = 270;    // 10 us at 27 MHz
  localparam int DEF_RETRY_W        = 4;

  // One counter serves every phase, so it is sized for the longest one.
  // Terminal compares are against N-1, so clog2(max) bits always suffice.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    int w;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    w = $clog2(m);
    if (w < 1) w = 1;
    return w;
  endfunction

endpackage

// File: rtl/pll_reset_sequencer_if.sv
// rtl/pll_reset_sequencer_if.sv - lock/reset/status bundle between the sequencer and its surroundings
//
// Signals:
//   lock            PLL lock, asynchronous to clk
//   soft_rst_req    synchronous request to re-sequence the PLL
//   pll_reset       registered reset to the PLL
//   sys_rst         registered active-high system reset
//   state           current sequencer state (seq_state_t encoding)
//   retry_count     saturating count of lock timeouts and lock losses
//   timeout_seen    sticky, set on any lock timeout
//   lock_lost_seen  sticky, set on lock loss while running
// Modports:
//   master  the sequencer (drives resets and status)
//   slave   PLL wrapper / system side (drives lock and soft_rst_req)

interface pll_reset_sequencer_if #(
  parameter int RETRY_W = 4
);

  logic               lock;
  logic               soft_rst_req;
  logic               pll_reset;
  logic               sys_rst;
  logic [1:0]         state;
  logic [RETRY_W-1:0] retry_count;
  logic               timeout_seen;
  logic               lock_lost_seen;

  modport master (
    input  lock,
    input  soft_rst_req,
    output pll_reset,
    output sys_rst,
    output state,
    output retry_count,
    output timeout_seen,
    output lock_lost_seen
  );

  modport slave (
    output lock,
    output soft_rst_req,
    input  pll_reset,
    input  sys_rst,
    input  state,
    input  retry_count,
    input  timeout_seen,
    input  lock_lost_seen
  );

endinterface

// File: rtl/pll_reset_sequencer_sync_2ff.sv
// rtl/pll_reset_sequencer_sync_2ff.sv - generic single-bit two-flop synchronizer
//
// Ports:
//   clk  destination clock
//   rst  asynchronous active-high reset, clears both flops to 0
//   d    asynchronous input level
//   q    synchronized level; d sampled at edge k appears on q after edge k+1

module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_reset_sequencer.sv
// rtl/pll_reset_sequencer.sv - PLL reset pulse, lock qualification and system reset release
//
// Ports:
//   clk    free-running oscillator clock (same net as PLL clkin)
//   reset  asynchronous active-high reset
//   bus    pll_reset_sequencer_if.master: lock / soft_rst_req in,
//          pll_reset / sys_rst / state / retry_count / sticky flags out
//
// Parameters:
//   PLL_RST_CYCLES  cycles pll_reset is held per pulse (>=1)
//   LOCK_TIMEOUT    cycles to wait for lock before re-pulsing the PLL
//   STABLE_CYCLES   cycles lock must hold before sys_rst is released
//   RETRY_W         width of the saturating retry counter

module pll_reset_sequencer
  import pll_reset_sequencer_pkg::*;
#(
  parameter int PLL_RST_CYCLES = DEF_PLL_RST_CYCLES,
  parameter int LOCK_TIMEOUT   = DEF_LOCK_TIMEOUT,
  parameter int STABLE_CYCLES  = DEF_STABLE_CYCLES,
  parameter int RETRY_W        = DEF_RETRY_W
) (
  input  logic                   clk,
  input  logic                   reset,
  pll_reset_sequencer_if.master  bus
);

  localparam int CNT_W = cnt_width(PLL_RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);

  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);

  seq_state_t         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic               timeout_seen_q, timeout_seen_d;
  logic               lock_lost_q, lock_lost_d;
  logic               pll_reset_q;
  logic               sys_rst_q;
  logic               lock_s;

  sync_2ff u_lock_sync (
    .clk (clk),
    .rst (reset),
    .d   (bus.lock),
    .q   (lock_s)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= ST_RESET_PLL;
      cnt_q          <= '0;
      retry_q        <= '0;
      timeout_seen_q <= 1'b0;
      lock_lost_q    <= 1'b0;
      pll_reset_q    <= 1'b1;
      sys_rst_q      <= 1'b1;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      retry_q        <= retry_d;
      timeout_seen_q <= timeout_seen_d;
      lock_lost_q    <= lock_lost_d;
      // Decoded from the next state so both resets change on the same
      // edge as the state they belong to, while still leaving a flop.
      pll_reset_q    <= (state_d == ST_RESET_PLL);
      sys_rst_q      <= (state_d != ST_RUN);
    end
  end

  always_comb begin
    state_d        = state_q;
    retry_d        = retry_q;
    timeout_seen_d = timeout_seen_q;
    lock_lost_d    = lock_lost_q;

    case (state_q)
      ST_RESET_PLL: begin
        // soft_rst_req deliberately has no effect while the PLL is held.
        if (cnt_q == RST_LAST) state_d = ST_WAIT_LOCK;
      end

      ST_WAIT_LOCK: begin
        if (bus.soft_rst_req) begin
          state_d = ST_RESET_PLL;
        end else if (lock_s) begin
          state_d = ST_STABILIZE;
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d        = ST_RESET_PLL;
          retry_d        = (retry_q == '1) ? retry_q : retry_q + 1'b1;
          timeout_seen_d = 1'b1;
        end
      end

      ST_STABILIZE: begin
        // A drop during qualification is treated as a glitch: go back to
        // waiting without re-pulsing the PLL or counting a retry.
        if (bus.soft_rst_req) begin
          state_d = ST_RESET_PLL;
        end else if (!lock_s) begin
          state_d = ST_WAIT_LOCK;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        if (bus.soft_rst_req) begin
          state_d = ST_RESET_PLL;
        end else if (!lock_s) begin
          state_d     = ST_RESET_PLL;
          retry_d     = (retry_q == '1) ? retry_q : retry_q + 1'b1;
          lock_lost_d = 1'b1;
        end
      end

      default: state_d = ST_RESET_PLL;
    endcase

    // Every phase times itself from zero; RUN has nothing to time.
    if (state_d != state_q || state_q == ST_RUN) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign bus.pll_reset      = pll_reset_q;
  assign bus.sys_rst        = sys_rst_q;
  assign bus.state          = state_q;
  assign bus.retry_count    = retry_q;
  assign bus.timeout_seen   = timeout_seen_q;
  assign bus.lock_lost_seen = lock_lost_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb/tb_pll_reset_sequencer.sv - directed self-checking bench for pll_reset_sequencer

module tb_pll_reset_sequencer;

  logic clk;
  logic reset;
  int   errors;
  int   checks;
  int   e;

  pll_reset_sequencer_if #(.RETRY_W(2)) bus ();

  pll_reset_sequencer #(
    .PLL_RST_CYCLES (4),
    .LOCK_TIMEOUT   (20),
    .STABLE_CYCLES  (8),
    .RETRY_W        (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after rising edge number n (edge 1 = first after reset release).
  task automatic step_to(input int n);
    while (e < n) begin
      @(posedge clk);
      #1;
      e++;
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_state"}, 32'(bus.state), 32'd0);
    chk({tag, "_pll_reset"}, 32'(bus.pll_reset), 32'd1);
    chk({tag, "_sys_rst"}, 32'(bus.sys_rst), 32'd1);
    chk({tag, "_retry"}, 32'(bus.retry_count), 32'd0);
    chk({tag, "_timeout_seen"}, 32'(bus.timeout_seen), 32'd0);
    chk({tag, "_lock_lost_seen"}, 32'(bus.lock_lost_seen), 32'd0);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    e = 0;
    reset = 1'b0;
    bus.lock = 1'b0;
    bus.soft_rst_req = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk_reset_vals("por");
    @(negedge clk);
    reset = 1'b0;

    // Nominal: lock sampled first at edge 10
    step_to(3);
    chk("nom_pll_hi_e3", 32'(bus.pll_reset), 32'd1);
    chk("nom_state_e3", 32'(bus.state), 32'd0);
    step_to(4);
    chk("nom_pll_lo_e4", 32'(bus.pll_reset), 32'd0);
    chk("nom_state_e4", 32'(bus.state), 32'd1);
    step_to(9);
    bus.lock = 1'b1;
    step_to(11);
    chk("nom_state_e11", 32'(bus.state), 32'd1);
    step_to(12);
    chk("nom_state_e12", 32'(bus.state), 32'd2);
    step_to(19);
    chk("nom_sys_e19", 32'(bus.sys_rst), 32'd1);
    step_to(20);
    chk("nom_sys_e20", 32'(bus.sys_rst), 32'd0);
    chk("nom_state_e20", 32'(bus.state), 32'd3);
    chk("nom_retry", 32'(bus.retry_count), 32'd0);
    chk("nom_pll_e20", 32'(bus.pll_reset), 32'd0);

    // Lock loss in RUN: sampled low at edge 23
    step_to(22);
    bus.lock = 1'b0;
    step_to(24);
    chk("loss_sys_e24", 32'(bus.sys_rst), 32'd0);
    chk("loss_state_e24", 32'(bus.state), 32'd3);
    step_to(25);
    chk("loss_sys_e25", 32'(bus.sys_rst), 32'd1);
    chk("loss_pll_e25", 32'(bus.pll_reset), 32'd1);
    chk("loss_state_e25", 32'(bus.state), 32'd0);
    chk("loss_flag", 32'(bus.lock_lost_seen), 32'd1);
    chk("loss_retry", 32'(bus.retry_count), 32'd1);
    chk("loss_timeout_seen", 32'(bus.timeout_seen), 32'd0);
    step_to(28);
    chk("reseq_state_e28", 32'(bus.state), 32'd0);
    step_to(29);
    chk("reseq_state_e29", 32'(bus.state), 32'd1);
    chk("reseq_pll_e29", 32'(bus.pll_reset), 32'd0);
    step_to(30);
    bus.lock = 1'b1;
    step_to(33);
    chk("reseq_state_e33", 32'(bus.state), 32'd2);
    step_to(40);
    chk("reseq_sys_e40", 32'(bus.sys_rst), 32'd1);
    step_to(41);
    chk("reseq_sys_e41", 32'(bus.sys_rst), 32'd0);
    chk("reseq_state_e41", 32'(bus.state), 32'd3);

    // Soft reset coinciding with lock_s loss at edge 45
    step_to(42);
    bus.lock = 1'b0;
    step_to(44);
    chk("soft_state_e44", 32'(bus.state), 32'd3);
    bus.soft_rst_req = 1'b1;
    step_to(45);
    bus.soft_rst_req = 1'b0;
    chk("soft_state_e45", 32'(bus.state), 32'd0);
    chk("soft_retry", 32'(bus.retry_count), 32'd1);
    chk("soft_lost_flag", 32'(bus.lock_lost_seen), 32'd1);
    chk("soft_pll_e45", 32'(bus.pll_reset), 32'd1);
    step_to(49);
    chk("soft_state_e49", 32'(bus.state), 32'd1);

    // Glitch during STABILIZE: low sampled at edges 59-60, high again at 61
    step_to(50);
    bus.lock = 1'b1;
    step_to(53);
    chk("glitch_state_e53", 32'(bus.state), 32'd2);
    step_to(58);
    bus.lock = 1'b0;
    step_to(60);
    chk("glitch_state_e60", 32'(bus.state), 32'd2);
    bus.lock = 1'b1;
    step_to(61);
    chk("glitch_state_e61", 32'(bus.state), 32'd1);
    chk("glitch_retry", 32'(bus.retry_count), 32'd1);
    step_to(62);
    chk("glitch_state_e62", 32'(bus.state), 32'd1);
    step_to(63);
    chk("glitch_state_e63", 32'(bus.state), 32'd2);
    step_to(70);
    chk("glitch_sys_e70", 32'(bus.sys_rst), 32'd1);
    step_to(71);
    chk("glitch_sys_e71", 32'(bus.sys_rst), 32'd0);
    chk("glitch_state_e71", 32'(bus.state), 32'd3);

    // Second lock loss, then timeouts with lock held low
    step_to(72);
    bus.lock = 1'b0;
    step_to(75);
    chk("loss2_state_e75", 32'(bus.state), 32'd0);
    chk("loss2_retry", 32'(bus.retry_count), 32'd2);
    step_to(79);
    chk("to_state_e79", 32'(bus.state), 32'd1);
    step_to(98);
    chk("to_state_e98", 32'(bus.state), 32'd1);
    chk("to_flag_e98", 32'(bus.timeout_seen), 32'd0);
    step_to(99);
    chk("to_state_e99", 32'(bus.state), 32'd0);
    chk("to_retry_e99", 32'(bus.retry_count), 32'd3);
    chk("to_flag_e99", 32'(bus.timeout_seen), 32'd1);
    chk("to_pll_e99", 32'(bus.pll_reset), 32'd1);
    step_to(103);
    chk("to_state_e103", 32'(bus.state), 32'd1);
    step_to(122);
    chk("to_pll_e122", 32'(bus.pll_reset), 32'd0);
    chk("to_state_e122", 32'(bus.state), 32'd1);
    step_to(123);
    chk("to_pll_e123", 32'(bus.pll_reset), 32'd1);
    chk("to_retry_sat", 32'(bus.retry_count), 32'd3);
    chk("to_sys_e123", 32'(bus.sys_rst), 32'd1);
    chk("to_state_e123", 32'(bus.state), 32'd0);

    // Lock already qualified when WAIT_LOCK is entered at edge 127
    bus.lock = 1'b1;
    step_to(127);
    chk("pre_state_e127", 32'(bus.state), 32'd1);
    step_to(128);
    chk("pre_state_e128", 32'(bus.state), 32'd2);
    step_to(136);
    chk("pre_state_e136", 32'(bus.state), 32'd3);
    chk("pre_sys_e136", 32'(bus.sys_rst), 32'd0);

    // Async reset between edges while running
    #2 reset = 1'b1;
    #1;
    chk_reset_vals("async");
    @(negedge clk);
    reset = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
